// File: rtl/i2c_master_byte_ctrl.sv
// Purpose: single-byte I2C master: START, 7-bit address + R/W, ACK, one data byte, ACK/NACK, STOP.
// Latency: done pulses 80*CLKS_PER_Q clk after acceptance (44*CLKS_PER_Q on address NACK).
// Backpressure: start is accepted only while idle (including the done cycle); start while busy is ignored.
module i2c_master_byte_ctrl #(
    parameter int CLKS_PER_Q = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] wdata,
    input  logic       sda_i,
    output logic       scl_o,
    output logic       sda_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_err,
    output logic [7:0] rdata
);

    localparam int CW = (CLKS_PER_Q > 1) ? $clog2(CLKS_PER_Q) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      qtr_q, qtr_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      adr_q, adr_d;     // {addr, rw}
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      rx_q, rx_d;
    logic [7:0]      rdata_q, rdata_d;
    logic            ack_err_q, ack_err_d;
    logic            done_q, done_d;
    logic            scl_q, scl_d;
    logic            oe_q, oe_d;

    logic            last_clk, end_bit, sample, rw_q;

    assign rw_q     = adr_q[0];
    assign last_clk = (cnt_q == CW'(CLKS_PER_Q - 1));
    assign end_bit  = last_clk && (qtr_q == 2'd3);
    assign sample   = last_clk && (qtr_q == 2'd2);

    // Next-state: quarter/bit sequencing, transaction latching, ACK and read-data sampling.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        qtr_d     = qtr_q;
        bit_d     = bit_q;
        adr_d     = adr_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;

        if (state_q != S_IDLE) begin
            if (last_clk) begin
                cnt_d = '0;
                qtr_d = qtr_q + 2'd1;   // wraps to 0 at the end of q3
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_START;
                    cnt_d     = '0;
                    qtr_d     = 2'd0;
                    bit_d     = 3'd0;
                    adr_d     = {addr, rw};
                    wdata_d   = wdata;
                    ack_err_d = 1'b0;
                end
            end
            S_START: begin
                if (end_bit) state_d = S_ADDR;
            end
            S_ADDR: begin
                if (end_bit) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_ACK1;
                end
            end
            S_ACK1: begin
                if (sample && sda_i) ack_err_d = 1'b1;
                // ack_err was cleared at acceptance, so it reflects only this ACK slot here
                if (end_bit) state_d = ack_err_q ? S_STOP : S_DATA;
            end
            S_DATA: begin
                if (sample && rw_q) rx_d = {rx_q[6:0], sda_i};
                if (end_bit) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = S_ACK2;
                end
            end
            S_ACK2: begin
                // on reads the master NACKs, so the line is not sampled
                if (sample && !rw_q && sda_i) ack_err_d = 1'b1;
                if (end_bit) state_d = S_STOP;
            end
            S_STOP: begin
                if (end_bit) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    if (rw_q && !ack_err_q) rdata_d = rx_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pad levels for the upcoming cycle; data bits only change SDA at the start of q0.
    always_comb begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
        unique case (state_d)
            S_IDLE:  ;
            S_START: oe_d = qtr_d[1];
            S_ADDR: begin
                scl_d = qtr_d[1];
                oe_d  = ~adr_q[~bit_d];
            end
            S_ACK1, S_ACK2: scl_d = qtr_d[1];
            S_DATA: begin
                scl_d = qtr_d[1];
                oe_d  = ~rw_q & ~wdata_q[~bit_d];
            end
            S_STOP: begin
                scl_d = qtr_d[1];
                oe_d  = (qtr_d != 2'd3);
            end
            default: ;
        endcase
    end

    // State and output registers; reset abandons any transfer without a STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            qtr_q     <= 2'd0;
            bit_q     <= 3'd0;
            adr_q     <= 8'h00;
            wdata_q   <= 8'h00;
            rx_q      <= 8'h00;
            rdata_q   <= 8'h00;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            qtr_q     <= qtr_d;
            bit_q     <= bit_d;
            adr_q     <= adr_d;
            wdata_q   <= wdata_d;
            rx_q      <= rx_d;
            rdata_q   <= rdata_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            oe_q      <= oe_d;
        end
    end

    assign scl_o   = scl_q;
    assign sda_oe  = oe_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign ack_err = ack_err_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Bench for i2c_master_byte_ctrl: bus-level slave model, bit scoreboard, vector table.
// Instance u_dut runs CLKS_PER_Q=1 vectors; u_dut3 runs one CLKS_PER_Q=3 write.
// All sampling is done on the falling clock edge.
module tb_i2c_master_byte_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, rw, sda_i, scl_o, sda_oe, busy, done, ack_err;
    logic [6:0] addr;
    logic [7:0] wdata, rdata;
    logic       slave_pull;

    logic       start3, rw3, sda_i3, scl3, oe3, busy3, done3, ack_err3;
    logic [6:0] addr3;
    logic [7:0] wdata3, rdata3;
    logic       pull3;

    assign sda_i  = ~(sda_oe | slave_pull);
    assign sda_i3 = ~(oe3 | pull3);

    i2c_master_byte_ctrl #(.CLKS_PER_Q(1)) u_dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .rw(rw), .wdata(wdata),
        .sda_i(sda_i), .scl_o(scl_o), .sda_oe(sda_oe), .busy(busy), .done(done),
        .ack_err(ack_err), .rdata(rdata)
    );

    i2c_master_byte_ctrl #(.CLKS_PER_Q(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .addr(addr3), .rw(rw3), .wdata(wdata3),
        .sda_i(sda_i3), .scl_o(scl3), .sda_oe(oe3), .busy(busy3), .done(done3),
        .ack_err(ack_err3), .rdata(rdata3)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model + scoreboard for u_dut ----------------
    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        logic       ack_a;   // slave ACKs address
        logic       ack_d;   // slave ACKs written data
        logic [7:0] sdata;   // byte the slave returns on reads
        logic       err;     // expected ack_err
        logic [7:0] rd;      // expected rdata at done
        int         lat;     // expected cycle of done after acceptance edge
        int         poke;    // cycle to pulse start while busy (-1 none)
        int         rst_at;  // cycle to assert reset (-1 none)
    } vec_t;

    bit   exp_q[$];
    int   exp_nbits = 18;
    logic cur_ack_a = 1'b0, cur_ack_d = 1'b0, cur_rw = 1'b0;
    logic [7:0] cur_sdata = 8'h00;

    logic scl_prev = 1'b1, line_prev = 1'b1, held = 1'b1, in_txn = 1'b0;
    int   rise_cnt = 0, fall_cnt = 0;

    function automatic logic pull_for(input int f);
        if (f == 8) return cur_ack_a;
        if (!cur_ack_a) return 1'b0;
        if (f >= 9 && f <= 16) return cur_rw & ~cur_sdata[16-f];
        if (f == 17) return ~cur_rw & cur_ack_d;
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            in_txn     = 1'b0;
            slave_pull = 1'b0;
        end else if (!in_txn && scl_o && scl_prev && line_prev && !sda_i) begin
            in_txn   = 1'b1;
            rise_cnt = 0;
            fall_cnt = 0;
        end else if (in_txn) begin
            if (scl_o && !scl_prev) begin
                if (rise_cnt < exp_nbits) begin
                    if (exp_q.size() == 0) check("sb_empty", 1, 0);
                    else check("sda_bit", sda_i, exp_q.pop_front());
                    held = sda_i;
                end
                rise_cnt++;
            end else if (scl_o && scl_prev) begin
                if (rise_cnt >= 1 && rise_cnt <= exp_nbits) check("sda_stable", sda_i, held);
                else if (rise_cnt == exp_nbits + 1 && !line_prev && sda_i) in_txn = 1'b0;
            end
            if (!scl_o && scl_prev) begin
                slave_pull = pull_for(fall_cnt);
                fall_cnt++;
            end
        end
        scl_prev  = scl_o;
        line_prev = ~(sda_oe | slave_pull);
    end

    // ---------------- slave model + monitor for u_dut3 ----------------
    logic scl3_prev = 1'b1, line3_prev = 1'b1, held3 = 1'b1, in3 = 1'b0;
    int   r3 = 0, f3 = 0, cyc3 = 0, last3 = 0, stops3 = 0;
    logic [7:0] got3_a = 8'h00, got3_d = 8'h00;

    always @(negedge clk) begin
        cyc3++;
        if (rst) begin
            in3   = 1'b0;
            pull3 = 1'b0;
        end else if (!in3 && scl3 && scl3_prev && line3_prev && !sda_i3) begin
            in3 = 1'b1;
            r3  = 0;
            f3  = 0;
        end else if (in3) begin
            if (scl3 && !scl3_prev) begin
                if (r3 >= 1 && r3 <= 17) check("scl_period3", cyc3 - last3, 12);
                if (r3 <= 7) got3_a = {got3_a[6:0], sda_i3};
                else if (r3 >= 9 && r3 <= 16) got3_d = {got3_d[6:0], sda_i3};
                held3 = sda_i3;
                last3 = cyc3;
                r3++;
            end else if (scl3 && scl3_prev) begin
                if (r3 >= 1 && r3 <= 18) check("sda_stable3", sda_i3, held3);
                else if (r3 == 19 && !line3_prev && sda_i3) begin
                    in3 = 1'b0;
                    stops3++;
                end
            end
            if (!scl3 && scl3_prev) begin
                pull3 = (f3 == 8 || f3 == 17);
                f3++;
            end
        end
        scl3_prev  = scl3;
        line3_prev = ~(oe3 | pull3);
    end

    // ---------------- drivers ----------------
    task automatic run_vec(input vec_t v);
        int k;
        int dones;
        bit got;
        @(negedge clk);
        cur_ack_a = v.ack_a;
        cur_ack_d = v.ack_d;
        cur_rw    = v.rw;
        cur_sdata = v.sdata;
        exp_nbits = v.ack_a ? 18 : 9;
        for (int i = 6; i >= 0; i--) exp_q.push_back(v.addr[i]);
        exp_q.push_back(v.rw);
        exp_q.push_back(!v.ack_a);
        if (v.ack_a) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(v.rw ? v.sdata[i] : v.wdata[i]);
            exp_q.push_back(v.rw ? 1'b1 : !v.ack_d);
        end
        start = 1'b1; addr = v.addr; rw = v.rw; wdata = v.wdata;
        @(negedge clk);
        start = 1'b0;
        addr  = 7'($urandom);
        rw    = 1'($urandom);
        wdata = 8'($urandom);
        k = 1;
        check("busy_acc", busy, 1'b1);
        check("err_clr", ack_err, 1'b0);
        got = 1'b0;
        while (k < 400 && !got) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (k == v.rst_at) begin
                    rst = 1'b1;
                    @(negedge clk);
                    check("rst_scl", scl_o, 1'b1);
                    check("rst_oe", sda_oe, 1'b0);
                    check("rst_busy", busy, 1'b0);
                    check("rst_rdata", rdata, 8'h00);
                    @(negedge clk);
                    rst = 1'b0;
                    exp_q.delete();
                    dones = 0;
                    repeat (100) begin
                        @(negedge clk);
                        if (done) dones++;
                    end
                    check("rst_no_done", dones, 0);
                    check("rst_idle_busy", busy, 1'b0);
                    return;
                end
                start = (k == v.poke);
                @(negedge clk);
                k++;
            end
        end
        start = 1'b0;
        check("done_lat", k, v.lat);
        check("ack_err", ack_err, v.err);
        check("rdata", rdata, v.rd);
        check("busy_at_done", busy, 1'b0);
        check("sb_left", exp_q.size(), 0);
        dones = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("extra_done", dones, 0);
        check("idle_busy", busy, 1'b0);
        check("idle_scl", scl_o, 1'b1);
        check("idle_oe", sda_oe, 1'b0);
        exp_q.delete();
    endtask

    task automatic run_cq3();
        int k;
        @(negedge clk);
        start3 = 1'b1; addr3 = 7'h50; rw3 = 1'b0; wdata3 = 8'hA5;
        @(negedge clk);
        start3 = 1'b0; addr3 = 7'h2B; rw3 = 1'b1; wdata3 = 8'h3C;
        k = 1;
        while (k < 600 && !done3) begin
            @(negedge clk);
            k++;
        end
        check("cq3_lat", k, 241);
        check("cq3_ack_err", ack_err3, 1'b0);
        check("cq3_addr_byte", got3_a, 8'hA0);
        check("cq3_data_byte", got3_d, 8'hA5);
        check("cq3_stops", stops3, 1);
        check("cq3_rdata", rdata3, 8'h00);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 81, -1, -1};
        vecs[1] = '{7'h22, 1'b0, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 45, -1, -1};
        vecs[2] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b0, 8'hC3, 81, -1, -1};
        vecs[3] = '{7'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'hC3, 81, -1, -1};
        vecs[4] = '{7'h01, 1'b1, 8'hFF, 1'b1, 1'b0, 8'h5A, 1'b0, 8'h5A, 81, -1, -1};
        vecs[5] = '{7'h11, 1'b1, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 8'h5A, 45, -1, -1};
        vecs[6] = '{7'h2A, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00, 1'b0, 8'h5A, 81, 62, -1};
        vecs[7] = '{7'h50, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 81, -1, 50};
        vecs[8] = '{7'h3C, 1'b1, 8'h00, 1'b1, 1'b0, 8'h96, 1'b0, 8'h96, 81, -1, -1};

        rst = 1'b1; start = 1'b0; addr = '0; rw = 1'b0; wdata = '0; slave_pull = 1'b0;
        start3 = 1'b0; addr3 = '0; rw3 = 1'b0; wdata3 = '0; pull3 = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_scl", scl_o, 1'b1);
        check("reset_oe", sda_oe, 1'b0);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_ack_err", ack_err, 1'b0);
        check("reset_rdata", rdata, 8'h00);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);
        run_cq3();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
